ysyx_22040237_ifu: RTL and testbench

YSYX_22040237_IFU -- requirements
Module: ysyx_22040237_ifu

---
 rtl/ysyx_22040237_pkg.sv | 20 ++
 rtl/ysyx_22040237_ifu_fifo.sv | 57 +++++
 rtl/ysyx_22040237_ifu.sv | 118 +++++++++++
 tb/tb_ysyx_22040237_ifu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_pkg.sv
// Shared widths, FSM encoding and buffer entry layout for the ysyx_22040237 core.
package ysyx_22040237_pkg;

  localparam int unsigned REG_WIDTH  = 64;
  localparam int unsigned INST_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  err;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_22040237_ifu_fifo.sv
// Fetch output buffer: circular FIFO with clear, accepts push+pop together when full.
module ysyx_22040237_ifu_fifo
  import ysyx_22040237_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             push,
  input  fetch_entry_t                     push_data,
  input  logic                             pop,
  output fetch_entry_t                     head,
  output logic [$clog2(DEPTH + 1)-1:0]     count,
  output logic                             empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // clear takes priority so an entry pushed in a flush cycle is discarded
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: single-outstanding imem requests feeding a small decode buffer.
module ysyx_22040237_ifu
  import ysyx_22040237_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  pc_i,
  input  logic                  flush_i,
  output logic                  pc_stall_o,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [REG_WIDTH-1:0]  imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [REG_WIDTH-1:0]  inst_pc_o,
  output logic                  inst_err_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  ifu_state_e           state, state_next;
  logic [REG_WIDTH-1:0] addr;
  logic                 drop;
  logic                 misaligned, has_space, push, pop, empty;
  fetch_entry_t         push_data, head;
  logic [CW-1:0]        count;

  assign misaligned = (pc_i[1:0] != 2'b00);
  assign has_space  = (count < CW'(FIFO_DEPTH));
  assign pop        = inst_valid_o && inst_ready_i;

  ysyx_22040237_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assign inst_valid_o    = !empty;
  assign inst_o          = head.inst;
  assign inst_pc_o       = head.pc;
  assign inst_err_o      = head.err;
  assign imem_req_addr_o = addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        // misaligned PCs also wait for buffer space so the error entry is never lost
        if (!flush_i && has_space) state_next = misaligned ? HALT : REQ;
      end
      REQ:  if (imem_req_ready_i) state_next = WAIT;
      WAIT: if (imem_rsp_valid_i) state_next = IDLE;
      HALT: if (flush_i)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid_o = 1'b0;
    push             = 1'b0;
    push_data        = '0;
    pc_stall_o       = 1'b1;
    unique case (state)
      IDLE: begin
        if (!flush_i && has_space && misaligned) begin
          push      = 1'b1;
          push_data = '{pc: pc_i, inst: '0, err: 1'b1};
        end
      end
      REQ:  imem_req_valid_o = 1'b1;
      WAIT: begin
        if (imem_rsp_valid_i && !drop) begin
          push       = !flush_i;
          push_data  = '{pc: addr, inst: imem_rsp_data_i, err: imem_rsp_err_i};
          pc_stall_o = 1'b0;
        end
      end
      default: ;
    endcase
    if (flush_i) pc_stall_o = 1'b0;
  end

  // drop marks the single outstanding response as stale; a response consumed in
  // the flush cycle itself is already discarded, so it must not arm drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      drop <= 1'b0;
    end else begin
      if (state == IDLE && state_next == REQ) addr <= pc_i;
      if (state == REQ && flush_i) drop <= 1'b1;
      else if (state == WAIT) begin
        if (imem_rsp_valid_i) drop <= 1'b0;
        else if (flush_i)     drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed bench for the fetch unit: reset, fetch, buffering, flush, misalignment.
module tb_ysyx_22040237_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_i;
  logic        flush_i;
  logic        pc_stall_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_err_o;

  int vecs = 0;
  int errs = 0;

  ysyx_22040237_ifu #(.FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_i),
    .flush_i          (flush_i),
    .pc_stall_o       (pc_stall_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_err_o       (inst_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic reset_dut(input logic [63:0] pc);
    rst = 1'b0;
    pc_i = pc;
    flush_i = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    imem_rsp_err_i = 1'b0;
    inst_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Ends at the negedge of the first cycle with a visible request.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Handshake at the next edge, then present a response in the WAIT cycle.
  task automatic respond(input logic [31:0] d, input logic e);
    @(posedge clk); #1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = d;
    imem_rsp_err_i = e;
    @(negedge clk);
  endtask

  task automatic end_rsp();
    @(posedge clk); #1;
    imem_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b0;
    pc_i = 64'h8000_0000;
    flush_i = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    imem_rsp_err_i = 1'b0;
    inst_ready_i = 1'b0;
    #12;
    vecs++; if (imem_req_valid_o !== 1'b0) begin errs++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid_o); end
    vecs++; if (inst_valid_o !== 1'b0) begin errs++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid_o); end
    vecs++; if (pc_stall_o !== 1'b1) begin errs++; $display("FAIL reset_pc_stall got %b exp 1", pc_stall_o); end
    vecs++; if (imem_req_addr_o !== 64'h0) begin errs++; $display("FAIL reset_addr got %h exp 0", imem_req_addr_o); end
    @(negedge clk);
    rst = 1'b1;
    imem_rsp_valid_i = 1'b1;      // stray response in the first cycle after reset
    imem_rsp_data_i = 32'hBADB_AD00;
    @(posedge clk); #1;
    imem_rsp_valid_i = 1'b0;
    @(negedge clk);
    vecs++; if (inst_valid_o !== 1'b0) begin errs++; $display("FAIL stray_rsp_ignored got inst_valid %b exp 0", inst_valid_o); end
    vecs++; if (imem_req_valid_o !== 1'b1) begin errs++; $display("FAIL req_latency got %b exp 1", imem_req_valid_o); end
    vecs++; if (imem_req_addr_o !== 64'h8000_0000) begin errs++; $display("FAIL req_addr got %h exp 80000000", imem_req_addr_o); end
    ok = 1'b1;
  endtask

  task automatic test_basic_fetch();
    bit ok;
    reset_dut(64'h8000_0000);
    wait_req(ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL basic_req_seen got %b exp 1", ok); end
    @(posedge clk); #1;
    @(negedge clk);
    vecs++; if (pc_stall_o !== 1'b1) begin errs++; $display("FAIL basic_wait_stall got %b exp 1", pc_stall_o); end
    vecs++; if (imem_req_valid_o !== 1'b0) begin errs++; $display("FAIL basic_wait_noreq got %b exp 0", imem_req_valid_o); end
    @(posedge clk); #1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h0000_0413;
    @(negedge clk);
    vecs++; if (pc_stall_o !== 1'b0) begin errs++; $display("FAIL basic_push_stall got %b exp 0", pc_stall_o); end
    vecs++; if (inst_valid_o !== 1'b0) begin errs++; $display("FAIL basic_not_yet_valid got %b exp 0", inst_valid_o); end
    end_rsp();
    pc_i = 64'h8000_0004;
    @(negedge clk);
    vecs++; if (inst_valid_o !== 1'b1) begin errs++; $display("FAIL basic_inst_valid got %b exp 1", inst_valid_o); end
    vecs++; if (inst_o !== 32'h0000_0413) begin errs++; $display("FAIL basic_inst got %h exp 00000413", inst_o); end
    vecs++; if (inst_pc_o !== 64'h8000_0000) begin errs++; $display("FAIL basic_inst_pc got %h exp 80000000", inst_pc_o); end
    vecs++; if (inst_err_o !== 1'b0) begin errs++; $display("FAIL basic_inst_err got %b exp 0", inst_err_o); end
    vecs++; if (pc_stall_o !== 1'b1) begin errs++; $display("FAIL basic_stall_one_cycle got %b exp 1", pc_stall_o); end
  endtask

  task automatic test_buffer_full();
    bit ok;
    logic [63:0] exp_pc;
    reset_dut(64'h8000_0000);
    exp_pc = 64'h8000_0000;
    for (int k = 0; k < 2; k++) begin
      wait_req(ok);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL full_req%0d_seen got %b exp 1", k, ok); end
      vecs++; if (imem_req_addr_o !== exp_pc) begin errs++; $display("FAIL full_req%0d_addr got %h exp %h", k, imem_req_addr_o, exp_pc); end
      respond(32'h1000_0000 | k, k[0]);
      end_rsp();
      exp_pc = exp_pc + 64'd4;
      pc_i = exp_pc;
    end
    wait_req(ok);
    vecs++; if (ok !== 1'b0) begin errs++; $display("FAIL full_no_third_req got %b exp 0", ok); end
    vecs++; if (inst_o !== 32'h1000_0000) begin errs++; $display("FAIL full_head0 got %h exp 10000000", inst_o); end
    @(posedge clk); #1;
    inst_ready_i = 1'b1;
    @(posedge clk); #1;
    inst_ready_i = 1'b0;
    @(negedge clk);
    vecs++; if (inst_o !== 32'h1000_0001) begin errs++; $display("FAIL full_head1 got %h exp 10000001", inst_o); end
    vecs++; if (inst_pc_o !== 64'h8000_0004) begin errs++; $display("FAIL full_head1_pc got %h exp 80000004", inst_pc_o); end
    vecs++; if (inst_err_o !== 1'b1) begin errs++; $display("FAIL full_head1_err got %b exp 1", inst_err_o); end
    wait_req(ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL full_req_after_pop got %b exp 1", ok); end
    vecs++; if (imem_req_addr_o !== 64'h8000_0008) begin errs++; $display("FAIL full_req_after_pop_addr got %h exp 80000008", imem_req_addr_o); end
  endtask

  task automatic test_flush_wait();
    bit ok;
    reset_dut(64'h8000_0000);
    wait_req(ok);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(negedge clk);
    vecs++; if (pc_stall_o !== 1'b0) begin errs++; $display("FAIL flushw_stall got %b exp 0", pc_stall_o); end
    @(posedge clk); #1;
    flush_i = 1'b0;
    pc_i = 64'h8000_1000;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    vecs++; if (pc_stall_o !== 1'b1) begin errs++; $display("FAIL flushw_drop_stall got %b exp 1", pc_stall_o); end
    end_rsp();
    @(negedge clk);
    vecs++; if (inst_valid_o !== 1'b0) begin errs++; $display("FAIL flushw_no_push got %b exp 0", inst_valid_o); end
    wait_req(ok);
    vecs++; if (imem_req_addr_o !== 64'h8000_1000) begin errs++; $display("FAIL flushw_new_addr got %h exp 80001000", imem_req_addr_o); end
    respond(32'h0000_0013, 1'b0);
    vecs++; if (pc_stall_o !== 1'b0) begin errs++; $display("FAIL flushw_drop_cleared got %b exp 0", pc_stall_o); end
    end_rsp();
    @(negedge clk);
    vecs++; if (inst_o !== 32'h0000_0013) begin errs++; $display("FAIL flushw_next_inst got %h exp 00000013", inst_o); end
  endtask

  task automatic test_flush_req();
    bit ok;
    reset_dut(64'h8000_0000);
    imem_req_ready_i = 1'b0;
    wait_req(ok);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    pc_i = 64'h8000_2000;
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    vecs++; if (imem_req_valid_o !== 1'b1) begin errs++; $display("FAIL flushr_req_held got %b exp 1", imem_req_valid_o); end
    vecs++; if (imem_req_addr_o !== 64'h8000_0000) begin errs++; $display("FAIL flushr_addr_stable got %h exp 80000000", imem_req_addr_o); end
    respond(32'h0000_1111, 1'b0);
    vecs++; if (pc_stall_o !== 1'b1) begin errs++; $display("FAIL flushr_drop_stall got %b exp 1", pc_stall_o); end
    end_rsp();
    @(negedge clk);
    vecs++; if (inst_valid_o !== 1'b0) begin errs++; $display("FAIL flushr_no_push got %b exp 0", inst_valid_o); end
    wait_req(ok);
    vecs++; if (imem_req_addr_o !== 64'h8000_2000) begin errs++; $display("FAIL flushr_new_addr got %h exp 80002000", imem_req_addr_o); end
  endtask

  task automatic test_misaligned();
    bit ok;
    bit saw_req;
    reset_dut(64'h8000_0002);
    @(negedge clk);
    vecs++; if (inst_valid_o !== 1'b1) begin errs++; $display("FAIL mis_entry got %b exp 1", inst_valid_o); end
    vecs++; if (inst_err_o !== 1'b1) begin errs++; $display("FAIL mis_err got %b exp 1", inst_err_o); end
    vecs++; if (inst_pc_o !== 64'h8000_0002) begin errs++; $display("FAIL mis_pc got %h exp 80000002", inst_pc_o); end
    vecs++; if (inst_o !== 32'h0) begin errs++; $display("FAIL mis_inst got %h exp 0", inst_o); end
    saw_req = imem_req_valid_o;
    inst_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_req = saw_req | imem_req_valid_o;
    end
    inst_ready_i = 1'b0;
    vecs++; if (saw_req !== 1'b0) begin errs++; $display("FAIL mis_halt_noreq got %b exp 0", saw_req); end
    vecs++; if (pc_stall_o !== 1'b1) begin errs++; $display("FAIL mis_halt_stall got %b exp 1", pc_stall_o); end
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    pc_i = 64'h8000_0100;
    wait_req(ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL mis_leave_halt got %b exp 1", ok); end
    vecs++; if (imem_req_addr_o !== 64'h8000_0100) begin errs++; $display("FAIL mis_new_addr got %h exp 80000100", imem_req_addr_o); end
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    reset_dut(64'h8000_0000);
    wait_req(ok);
    respond(32'h0000_0013, 1'b0);
    end_rsp();
    pc_i = 64'h8000_0004;
    imem_req_ready_i = 1'b0;
    wait_req(ok);
    vecs++; if (inst_valid_o !== 1'b1) begin errs++; $display("FAIL midrst_pre_entry got %b exp 1", inst_valid_o); end
    #2;
    rst = 1'b0;
    #1;
    vecs++; if (imem_req_valid_o !== 1'b0) begin errs++; $display("FAIL midrst_req_valid got %b exp 0", imem_req_valid_o); end
    vecs++; if (inst_valid_o !== 1'b0) begin errs++; $display("FAIL midrst_fifo_empty got %b exp 0", inst_valid_o); end
    vecs++; if (pc_stall_o !== 1'b1) begin errs++; $display("FAIL midrst_stall got %b exp 1", pc_stall_o); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_buffer_full();
    test_flush_wait();
    test_flush_req();
    test_misaligned();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
